// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_stage_elastic_pkg: shared stage states and occupancy decode for elastic pipeline stages
package pipe_stage_elastic_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} stage_state_t;
  function automatic logic [1:0] occupancy_of(stage_state_t s);
    return (s == SKID) ? 2'd2 : (s == FULL) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
// ports: clk, reset (sync, active-high), inc (count enable), count (current value)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with optional 2-entry skid, flush and stall counter
// ports: clk, reset (sync, active-high); in_valid/in_ready/in_data upstream handshake;
//        flush drops all held entries; out_valid/out_ready/out_data downstream handshake;
//        occupancy = entries held (0..2); stall_cnt = saturating count of stalled output cycles
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  stage_state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  // SKID=1 decodes in_ready from state only so no ready path crosses the stage;
  // SKID=0 lets a full stage accept when downstream drains in the same cycle.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != pipe_stage_elastic_pkg::SKID);
    end else begin : g_noskid
      assign in_ready = (state_q == EMPTY) | out_ready;
    end
  endgenerate
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = occupancy_of(state_q);
  // With SKID=0, in_fire & !out_fire is unreachable from FULL, so the skid entry is never used.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = FULL;
          main_d  = in_data;
        end
        FULL: if (in_fire && out_fire) main_d = in_data;
          else if (in_fire) begin
            state_d = pipe_stage_elastic_pkg::SKID;
            skid_d  = in_data;
          end else if (out_fire) state_d = EMPTY;
        pipe_stage_elastic_pkg::SKID: if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );
endmodule
